// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapaths: the inverse S-box, GF(2^8) constant
// multipliers, the state type and the decrypt FSM encoding.
package aes_pkg;
  localparam int NR = 10;

  // Byte 0 sits in the MSBs. Byte index is r + 4*c, so the layout is column-major.
  typedef logic [0:15][7:0] aes_state_t;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_LAST, S_DONE} dec_fsm_e;

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
endpackage

// File: rtl/aes_decrypt_core_if.sv
// Block-in / block-out handshakes plus the round-key store lookup for the decrypt core.
interface aes_decrypt_core_if #(parameter int RKW = 4);
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [RKW-1:0] rk_idx;
  logic [127:0]   rk;
  logic           out_valid;
  logic           out_ready;
  logic [127:0]   out_data;

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data
  );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational inverse round, in the order InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns. The last round skips the mix.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_state_t state,
  input  aes_state_t key,
  input  logic       last_round,
  output aes_state_t out
);
  aes_state_t sub, ark, mix;

  always_comb begin
    sub = '0;
    // Row r rotates right by r, so the output column c takes its byte from column c-r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub[r + 4*c] = inv_sbox(state[r + 4*((c - r + 4) % 4)]);
    ark = sub ^ key;
    mix = '0;
    for (int c = 0; c < 4; c++) begin
      mix[4*c]   = gf_mul14(ark[4*c]) ^ gf_mul11(ark[4*c+1]) ^ gf_mul13(ark[4*c+2]) ^ gf_mul9(ark[4*c+3]);
      mix[4*c+1] = gf_mul9(ark[4*c])  ^ gf_mul14(ark[4*c+1]) ^ gf_mul11(ark[4*c+2]) ^ gf_mul13(ark[4*c+3]);
      mix[4*c+2] = gf_mul13(ark[4*c]) ^ gf_mul9(ark[4*c+1])  ^ gf_mul14(ark[4*c+2]) ^ gf_mul11(ark[4*c+3]);
      mix[4*c+3] = gf_mul11(ark[4*c]) ^ gf_mul13(ark[4*c+1]) ^ gf_mul9(ark[4*c+2])  ^ gf_mul14(ark[4*c+3]);
    end
    out = last_round ? ark : mix;
  end
endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decrypt core that runs one inverse round per clock. The round key is
// read combinationally from an external store at the registered index rk_idx.
module aes_decrypt_core #(
  parameter int NR  = aes_pkg::NR,
  parameter int RKW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  aes_decrypt_core_if.slave  bus,
  output logic               busy
);
  import aes_pkg::*;

  if (NR != 10) begin : g_bad_nr
    $error("aes_decrypt_core supports only NR=10 (AES-128)");
  end

  dec_fsm_e       fsm, fsm_nxt;
  logic [RKW-1:0] cnt, cnt_nxt;
  logic [RKW-1:0] idx, idx_nxt;
  aes_state_t     st, st_nxt, round_out;

  aes_inv_round u_round (
    .state      (st),
    .key        (aes_state_t'(bus.rk)),
    .last_round (fsm == S_LAST),
    .out        (round_out)
  );

  // The key index is registered next to the FSM, so rk_idx is stable from the start of each cycle.
  always_comb begin
    fsm_nxt = fsm;
    cnt_nxt = cnt;
    idx_nxt = idx;
    st_nxt  = st;
    unique case (fsm)
      S_IDLE: if (bus.in_valid) begin
        st_nxt  = aes_state_t'(bus.in_data) ^ aes_state_t'(bus.rk);
        cnt_nxt = RKW'(9);
        idx_nxt = RKW'(9);
        fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        st_nxt  = round_out;
        cnt_nxt = cnt - RKW'(1);
        idx_nxt = cnt - RKW'(1);
        if (cnt == RKW'(1)) fsm_nxt = S_LAST;
      end
      S_LAST: begin
        st_nxt  = round_out;
        idx_nxt = RKW'(10);
        fsm_nxt = S_DONE;
      end
      S_DONE: if (bus.out_ready) fsm_nxt = S_IDLE;
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= S_IDLE;
      cnt <= '0;
      idx <= RKW'(10);
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
      st  <= st_nxt;
    end
  end

  assign bus.in_ready  = (fsm == S_IDLE);
  assign bus.out_valid = (fsm == S_DONE);
  assign bus.out_data  = st;
  assign bus.rk_idx    = idx;
  assign busy          = (fsm != S_IDLE);
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core. It uses FIPS-197 and SP800-38A vectors, full key
// schedules held in a bench-side key store, and checks backpressure, reset and back-to-back operation.
module tb_aes_decrypt_core;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   key_sel = 0;
  logic [127:0] ks [2][11];

  aes_decrypt_core_if #(.RKW(4)) bus ();

  aes_decrypt_core #(.NR(10), .RKW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.rk = '0;
    if (bus.rk_idx <= 4'd10) bus.rk = ks[key_sel][bus.rk_idx];
  end

  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the core is in IDLE. Returns at the first negedge with out_valid high.
  task automatic run_block(input logic [127:0] ct, input int ksel, input logic [127:0] pt,
                           input string tag);
    int n;
    bit idx_ok;
    key_sel      = ksel;
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    chk({tag, "_idle_idx"}, 128'(bus.rk_idx), 128'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    idx_ok = 1'b1;
    while (!bus.out_valid && n < 30) begin
      if (n > 9 || bus.rk_idx !== 4'(9 - n)) idx_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
    chk({tag, "_rk_trace"}, 128'({idx_ok, bus.rk_idx}), 128'({1'b1, 4'd10}));
    chk({tag, "_data"}, bus.out_data, pt);
  endtask

  logic [127:0] held;
  bit           stable;
  int           cyc, nacc, nout;
  int           acc_t [3];
  logic [127:0] bb_ct [3];
  logic [127:0] bb_pt [3];
  int           bb_k  [3];

  initial begin
    ks[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
              128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
              128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
              128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
              128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
              128'h13111d7fe3944a17f307a78b4d2b30c5};
    ks[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
              128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
              128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
              128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
              128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
    chk("rst_out_data", bus.out_data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with out_ready high.
    run_block(CT0, 0, PT0, "c1");
    @(negedge clk);
    chk("c1_back_idle", 128'({bus.in_ready, busy}), 128'b10);

    // SP800-38A ECB vector, held under backpressure.
    bus.out_ready = 1'b0;
    run_block(CT1, 1, PT1, "a1");
    held = bus.out_data;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_data !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold", 128'(stable), 128'd1);
    chk("bp_data", bus.out_data, PT1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 128'({bus.in_ready, bus.out_valid, busy}), 128'b100);

    // Reset while round 5 is in progress.
    key_sel = 0;
    bus.in_data  = CT0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_pre_busy", 128'(busy), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", 128'({bus.in_ready, bus.out_valid, busy}), 128'b100);
    chk("mid_rst_idx", 128'(bus.rk_idx), 128'd10);
    chk("mid_rst_data", bus.out_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_idle", 128'({bus.in_ready, bus.out_valid}), 128'b10);
    run_block(CT0, 0, PT0, "mid_c1");
    @(negedge clk);

    // Back-to-back: in_valid stays high, and the next block is queued while the current one is in DONE.
    bb_ct = '{CT0, CT1, CT0};
    bb_pt = '{PT0, PT1, PT0};
    bb_k  = '{0, 1, 0};
    key_sel = bb_k[0];
    bus.in_data  = bb_ct[0];
    bus.in_valid = 1'b1;
    cyc = 0; nacc = 0; nout = 0;
    while (nout < 3 && cyc < 100) begin
      if (bus.in_ready && nacc < 3) begin
        acc_t[nacc] = cyc;
        nacc++;
      end
      if (bus.out_valid) begin
        chk($sformatf("bb_data%0d", nout), bus.out_data, bb_pt[nout]);
        nout++;
        if (nout < 3) begin
          bus.in_data = bb_ct[nout];
          key_sel     = bb_k[nout];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("bb_count", 128'({nacc[3:0], nout[3:0]}), 128'({4'd3, 4'd3}));
    chk("bb_gap01", 128'(acc_t[1] - acc_t[0]), 128'd12);
    chk("bb_gap12", 128'(acc_t[2] - acc_t[1]), 128'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
